// File: rtl/data_mem_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
// The request side is registered in the controller; ack is a single-cycle completion pulse.
interface data_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store responder: turns each access into one req/ack transaction,
// stalls the pipeline until it completes and returns registered load data.
//
// state | meaning
// IDLE  | waiting for an access; stall_o follows acc combinationally
// REQ   | request outstanding on the memory bus, timeout counter running
// DONE  | one-cycle completion; pipeline advances at the closing edge
module data_mem_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic [31:0]           rdata_o,
    output logic                  misalign_o,
    output logic                  timeout_o,
    data_mem_ctrl_if.master       mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    logic acc;
    logic misal;
    logic to_hit;

    assign acc    = start_i & (MemRead_i | MemWrite_i);
    assign misal  = (addr_i[1:0] != 2'b00);
    assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (acc) state_d = misal ? S_DONE : S_REQ;
            S_REQ:   if (mem.mem_ack || to_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_o = acc;
                if (acc) begin
                    if (misal) begin
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = MemWrite_i;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // an ack in the last allowed cycle beats the timeout
                if (mem.mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = mem.mem_rdata;
                end else if (to_hit) begin
                    req_d     = 1'b0;
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rdata_o       = rdata_q;
    assign misalign_o    = misalign_q;
    assign timeout_o     = timeout_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed and random loads/stores against a
// transaction-level model of stall length, request length, pulses and load data.
module tb_data_mem_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_rdata = '0;

    data_mem_ctrl_if mem_if ();

    data_mem_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .rdata_o    (rdata_o),
        .misalign_o (misalign_o),
        .timeout_o  (timeout_o),
        .mem        (mem_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stall_n;
        int          req_n;
        int          mis_n;
        int          to_n;
        logic [31:0] rdata;
        logic        we;
        logic        stable;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        done;
        logic        post_ok;
    } obs_t;

    typedef struct {
        int          stall_n;
        int          req_n;
        int          mis_n;
        int          to_n;
        logic [31:0] rdata;
    } exp_t;

    // Transaction-level model: lat = REQ cycle in which the memory acks (0 = never).
    task automatic model(input logic wr, input logic [31:0] a, input int lat,
                         input logic [31:0] mval, output exp_t e);
        e.mis_n = 0;
        e.to_n  = 0;
        if (a[1:0] != 2'b00) begin
            e.stall_n = 1; e.req_n = 0; e.mis_n = 1; ref_rdata = '0;
        end else if (lat >= 1 && lat <= TO) begin
            e.stall_n = lat + 1; e.req_n = lat;
            if (!wr) ref_rdata = mval;
        end else begin
            e.stall_n = TO + 1; e.req_n = TO; e.to_n = 1; ref_rdata = '0;
        end
        e.rdata = ref_rdata;
    endtask

    // Drives one access and acts as the memory; returns what was observed.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input int lat,
                             input logic [31:0] mval, output obs_t o);
        logic seen = 1'b0;
        o = '{stall_n: 0, req_n: 0, mis_n: 0, to_n: 0, rdata: '0, we: 1'b0,
              stable: 1'b1, addr: '0, wdata: '0, done: 1'b0, post_ok: 1'b0};
        @(posedge clk); #2;
        start_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (stall_o) begin o.stall_n++; seen = 1'b1; end
            if (mem_if.mem_req) begin
                o.req_n++;
                if (o.req_n == 1) begin
                    o.we = mem_if.mem_we; o.addr = mem_if.mem_addr; o.wdata = mem_if.mem_wdata;
                end else if (mem_if.mem_we !== o.we || mem_if.mem_addr !== o.addr ||
                             mem_if.mem_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
            end
            if (misalign_o) o.mis_n++;
            if (timeout_o)  o.to_n++;
            mem_if.mem_ack   = mem_if.mem_req && (o.req_n == lat);
            mem_if.mem_rdata = mem_if.mem_ack ? mval : $urandom;
            if (seen && !stall_o) begin
                o.done = 1'b1;
                o.rdata = rdata_o;
                start_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
                mem_if.mem_ack = 1'b0;
                break;
            end
        end
        start_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_if.mem_ack = 1'b0;
        @(negedge clk);
        o.post_ok = !stall_o && !mem_if.mem_req && !misalign_o && !timeout_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || rdata_o !== 32'h0 || misalign_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b rdata=%h mis=%b to=%b, want all 0",
                     stall_o, rdata_o, misalign_o, timeout_o);
        end
        checks++;
        if (mem_if.mem_req !== 1'b0 || mem_if.mem_we !== 1'b0 || mem_if.mem_addr !== 32'h0 ||
            mem_if.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h, want all 0",
                     mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata);
        end
        rst_i = 1'b1;
        ref_rdata = '0;
    endtask

    task automatic test_directed();
        logic        t_rd[6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        t_wr[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] t_a[6]    = '{32'h10, 32'h20, 32'h13, 32'h40, 32'h44, 32'h50};
        logic [31:0] t_wd[6]   = '{32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
        int          t_lat[6]  = '{1, 4, 1, 0, 4, 2};
        logic [31:0] t_mv[6]   = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h11111111, 32'hCAFEF00D, 32'h0};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            do_access(t_rd[i], t_wr[i], t_a[i], t_wd[i], t_lat[i], t_mv[i], o);
            model(t_wr[i], t_a[i], t_lat[i], t_mv[i], e);
            checks++;
            if (o.done !== 1'b1 || o.post_ok !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_complete: done=%b post_idle=%b, want 1 1", i, o.done, o.post_ok);
            end
            checks++;
            if (o.stall_n != e.stall_n || o.req_n != e.req_n) begin
                errors++;
                $display("FAIL dir%0d_cycles: stall=%0d req=%0d, want stall=%0d req=%0d",
                         i, o.stall_n, o.req_n, e.stall_n, e.req_n);
            end
            checks++;
            if (o.mis_n != e.mis_n || o.to_n != e.to_n) begin
                errors++;
                $display("FAIL dir%0d_pulses: mis=%0d to=%0d, want mis=%0d to=%0d",
                         i, o.mis_n, o.to_n, e.mis_n, e.to_n);
            end
            checks++;
            if (o.rdata !== e.rdata) begin
                errors++;
                $display("FAIL dir%0d_rdata: got %h, want %h", i, o.rdata, e.rdata);
            end
            if (e.req_n > 0) begin
                checks++;
                if (o.we !== t_wr[i] || o.addr !== t_a[i] || o.wdata !== t_wd[i] || o.stable !== 1'b1) begin
                    errors++;
                    $display("FAIL dir%0d_bus: we=%b addr=%h wdata=%h stable=%b, want we=%b addr=%h wdata=%h stable=1",
                             i, o.we, o.addr, o.wdata, o.stable, t_wr[i], t_a[i], t_wd[i]);
                end
            end
        end
    endtask

    task automatic test_gating();
        int bad = 0;
        @(posedge clk); #2;
        start_i = 1'b0; MemRead_i = 1'b1; addr_i = 32'h10;
        repeat (4) begin
            @(negedge clk);
            if (stall_o !== 1'b0 || mem_if.mem_req !== 1'b0) bad++;
        end
        MemRead_i = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gating_start_low: %0d cycles with stall/req active, want 0", bad);
        end
        checks++;
        if (rdata_o !== ref_rdata) begin
            errors++;
            $display("FAIL gating_rdata: got %h, want %h", rdata_o, ref_rdata);
        end
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #2;
        start_i = 1'b1; MemRead_i = 1'b1; addr_i = 32'h60; mem_if.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_if.mem_req !== 1'b1 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL midreq_inflight: req=%b stall=%b, want 1 1", mem_if.mem_req, stall_o);
        end
        rst_i = 1'b0; start_i = 1'b0; MemRead_i = 1'b0;
        @(negedge clk);
        ref_rdata = '0;
        checks++;
        if (mem_if.mem_req !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL midreq_reset_edge: req=%b stall=%b rdata=%h, want 0 0 0",
                     mem_if.mem_req, stall_o, rdata_o);
        end
        rst_i = 1'b1; mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_if.mem_req !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL midreq_late_ack: req=%b stall=%b rdata=%h to=%b, want 0 0 0 0",
                     mem_if.mem_req, stall_o, rdata_o, timeout_o);
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            int          op  = int'($urandom_range(0, 2));
            logic        rd  = (op != 1);
            logic        wr  = (op != 0);
            logic [31:0] a   = $urandom;
            logic [31:0] wd  = $urandom;
            logic [31:0] mv  = $urandom;
            int          lat = int'($urandom_range(0, 6));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_access(rd, wr, a, wd, lat, mv, o);
            model(wr, a, lat, mv, e);
            checks++;
            if (o.done !== 1'b1 || o.post_ok !== 1'b1 || o.stall_n != e.stall_n || o.req_n != e.req_n) begin
                errors++;
                $display("FAIL rnd%0d_cycles: done=%b post=%b stall=%0d req=%0d, want 1 1 %0d %0d",
                         i, o.done, o.post_ok, o.stall_n, o.req_n, e.stall_n, e.req_n);
            end
            checks++;
            if (o.mis_n != e.mis_n || o.to_n != e.to_n || o.rdata !== e.rdata) begin
                errors++;
                $display("FAIL rnd%0d_result: mis=%0d to=%0d rdata=%h, want %0d %0d %h",
                         i, o.mis_n, o.to_n, o.rdata, e.mis_n, e.to_n, e.rdata);
            end
            if (e.req_n > 0) begin
                checks++;
                if (o.we !== wr || o.addr !== a || o.wdata !== wd || o.stable !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd%0d_bus: we=%b addr=%h wdata=%h stable=%b, want %b %h %h 1",
                             i, o.we, o.addr, o.wdata, o.stable, wr, a, wd);
                end
            end
        end
    endtask

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        test_reset();
        test_directed();
        test_gating();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
